i_memory_stage: RTL and testbench
=================================

I_MEMORY_STAGE -- requirements
Module: i_memory_stage

Interface
REQ-001 SHALL have parameter DMEM_DEPTH, default 32, meaning data memory depth in 64-bit words.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  execute result available; in_ready  output  1  stage can accept.
REQ-005 SHALL have alu_result, branch_target, read_data2  input  `WORD each  execute outputs; zero  input  1.
REQ-006 SHALL have mem_read, mem_write, branch, uncond_branch, reg_write, mem_to_reg  input  1 each  control bits; write_reg  input  5.
REQ-007 SHALL have out_valid  output  1; out_ready  input  1  writeback accepts.
REQ-008 SHALL have read_data, alu_result_out, branch_target_out  output  `WORD each; write_reg_out  output  5; reg_write_out, mem_to_reg_out, pc_src, mem_err  output  1 each.

Function
REQ-009 SHALL implement FSM states IDLE, READ, RESP.
REQ-010 SHALL assert in_ready only in IDLE; transfer occurs on in_valid && in_ready.
REQ-011 SHALL, on transfer, capture all inputs into the EX/MEM register; go to READ if mem_read=1, else RESP.
REQ-012 SHALL form word index = alu_result >> 3; access is legal only when alu_result[2:0]=0 and index < DMEM_DEPTH.
REQ-013 SHALL perform a store in the cycle after transfer, writing captured read_data2 to the indexed word, only when mem_write=1 and legal.
REQ-014 SHALL issue the synchronous RAM read in READ (one cycle) and register read_data on entry to RESP; total load latency 2 cycles from transfer to out_valid.
REQ-015 SHALL set read_data=0 for non-load or illegal access; mem_err=1 when (mem_read|mem_write) and access illegal; illegal store writes nothing.
REQ-016 SHALL drive pc_src = (branch & zero) | uncond_branch from captured values, meaningful only while out_valid=1.
REQ-017 SHALL assert out_valid only in RESP, holding all outputs stable until out_ready=1; then return to IDLE.
REQ-018 SHALL give non-load latency of 1 cycle from transfer to out_valid.
REQ-019 SHALL ignore mem_read when mem_write is also 1 (store takes priority; mem_err unaffected).
REQ-020 SHALL ignore in_valid outside IDLE (no capture, no overwrite).

Reset
REQ-021 SHALL on rst_n=0 immediately enter IDLE and clear out_valid, pc_src, mem_err, reg_write_out, mem_to_reg_out, write_reg_out, read_data, alu_result_out, branch_target_out to 0.
REQ-022 SHALL abort a pending store or load when reset asserts mid-operation; memory contents SHALL NOT be cleared by reset.
REQ-023 SHALL hold in_ready=0 while rst_n=0, asserting it the first cycle after release.

Structure
REQ-024 SHALL take `WORD (64) from definitions.vh; DMEM_DEPTH default and FSM state encodings SHALL be added there.
REQ-025 SHALL instantiate one sub-module, dmem: synchronous single-port RAM, DMEM_DEPTH x `WORD, with write enable and registered read.

Verification
REQ-026 Store: reset, transfer alu_result=112, read_data2=101, mem_write=1 -> out_valid 1 cycle later, mem_err=0, word 14 = 101.
REQ-027 Load: after REQ-026, transfer alu_result=112, mem_read=1, mem_to_reg=1, write_reg=9 -> out_valid 2 cycles later, read_data=101, write_reg_out=9.
REQ-028 CBZ: branch=1, zero=1, branch_target=0x0C -> pc_src=1, branch_target_out=0x0C; repeat with zero=0 -> pc_src=0; uncond_branch=1, zero=0 -> pc_src=1.
REQ-029 Illegal: mem_read=1, alu_result=0x104 (unaligned) and then 0x100 (out of range) -> mem_err=1, read_data=0, memory unchanged.
REQ-030 Backpressure: ADD result 30, out_ready=0 for 3 cycles -> out_valid and alu_result_out=30 stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-031 Reset mid-load: rst_n=0 in READ -> outputs 0 immediately, IDLE after release, stored word 14 still 101.

Source files
------------

// File: rtl/i_memory_stage_pkg.sv
// Shared definitions for the memory stage: datapath width, default memory
// depth, FSM state encoding and an address-width helper.
package i_memory_stage_pkg;

  localparam int unsigned WORD               = 64;
  localparam int unsigned DMEM_DEPTH_DEFAULT = 32;
  localparam int unsigned REG_AW             = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Index width for a memory of the given depth (never below one bit).
  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/i_memory_stage_dmem.sv
// Synchronous single-port data memory: write-enabled store, registered read.
// The array itself is never reset; only the read register is.
module i_memory_stage_dmem
  import i_memory_stage_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int unsigned AW    = addr_bits(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic            i_re,
  input  logic [AW-1:0]   i_addr,
  input  logic [WORD-1:0] i_wdata,
  output logic [WORD-1:0] o_rdata
);

  logic [WORD-1:0] r_mem [DEPTH];
  logic [WORD-1:0] r_rdata;

  // Store path: array contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/i_memory_stage.sv
// EX/MEM pipeline register plus data-memory access with a valid/ready
// handshake on both sides. Loads take an extra READ cycle for the RAM.
module i_memory_stage
  import i_memory_stage_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD-1:0]   alu_result,
  input  logic [WORD-1:0]   branch_target,
  input  logic [WORD-1:0]   read_data2,
  input  logic              zero,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [REG_AW-1:0] write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD-1:0]   read_data,
  output logic [WORD-1:0]   alu_result_out,
  output logic [WORD-1:0]   branch_target_out,
  output logic [REG_AW-1:0] write_reg_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              pc_src,
  output logic              mem_err
);

  localparam int unsigned AW = addr_bits(DMEM_DEPTH);

  state_e r_state;
  state_e w_state_nxt;

  logic [WORD-1:0]   r_alu;
  logic [WORD-1:0]   r_bt;
  logic [WORD-1:0]   r_rd2;
  logic              r_zero;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;
  logic              r_uncond;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [REG_AW-1:0] r_write_reg;
  logic              r_store_pend;

  logic              w_xfer;
  logic [WORD-1:0]   w_index;
  logic              w_legal;
  logic              w_is_load;
  logic [AW-1:0]     w_addr;
  logic [WORD-1:0]   w_rdata;

  assign in_ready  = (r_state == ST_IDLE) && rst_n;
  assign w_xfer    = in_valid && in_ready;
  assign w_index   = r_alu >> 3;
  assign w_legal   = (r_alu[2:0] == 3'b000) && (w_index < WORD'(DMEM_DEPTH));
  assign w_addr    = w_index[AW-1:0];
  // A store takes priority over a load when both bits are set.
  assign w_is_load = r_mem_read && !r_mem_write;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: loads detour through READ, everything else goes to RESP.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = (mem_read && !mem_write) ? ST_READ : ST_RESP;
        end
      end
      ST_READ: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // EX/MEM register: captured only on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu        <= '0;
      r_bt         <= '0;
      r_rd2        <= '0;
      r_zero       <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_uncond     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_write_reg  <= '0;
    end else if (w_xfer) begin
      r_alu        <= alu_result;
      r_bt         <= branch_target;
      r_rd2        <= read_data2;
      r_zero       <= zero;
      r_mem_read   <= mem_read;
      r_mem_write  <= mem_write;
      r_branch     <= branch;
      r_uncond     <= uncond_branch;
      r_reg_write  <= reg_write;
      r_mem_to_reg <= mem_to_reg;
      r_write_reg  <= write_reg;
    end
  end

  // One-shot store request for the cycle after transfer; reset cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store_pend <= 1'b0;
    end else begin
      r_store_pend <= w_xfer && mem_write;
    end
  end

  i_memory_stage_dmem #(
    .DEPTH (DMEM_DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (r_store_pend && w_legal),
    .i_re    ((r_state == ST_READ) && w_legal),
    .i_addr  (w_addr),
    .i_wdata (r_rd2),
    .o_rdata (w_rdata)
  );

  // The RAM read register is the read_data register; it is masked to zero
  // for anything that is not a legal load.
  assign read_data         = (w_is_load && w_legal) ? w_rdata : '0;
  assign out_valid         = (r_state == ST_RESP);
  assign alu_result_out    = r_alu;
  assign branch_target_out = r_bt;
  assign write_reg_out     = r_write_reg;
  assign reg_write_out     = r_reg_write;
  assign mem_to_reg_out    = r_mem_to_reg;
  assign pc_src            = (r_branch && r_zero) || r_uncond;
  assign mem_err           = (r_mem_read || r_mem_write) && !w_legal;

endmodule

// File: tb/tb_i_memory_stage.sv
module tb_i_memory_stage;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result, branch_target, read_data2;
  logic        zero, mem_read, mem_write, branch, uncond_branch, reg_write, mem_to_reg;
  logic [4:0]  write_reg;
  logic        out_valid, out_ready;
  logic [63:0] read_data, alu_result_out, branch_target_out;
  logic [4:0]  write_reg_out;
  logic        reg_write_out, mem_to_reg_out, pc_src, mem_err;

  i_memory_stage #(.DMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .branch_target(branch_target), .read_data2(read_data2),
    .zero(zero), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .uncond_branch(uncond_branch), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .write_reg(write_reg), .out_valid(out_valid), .out_ready(out_ready),
    .read_data(read_data), .alu_result_out(alu_result_out),
    .branch_target_out(branch_target_out), .write_reg_out(write_reg_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .pc_src(pc_src), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] alu, bt, rd2;
    logic zero, mr, mw, br, ub, rw, m2r;
    logic [4:0] wr;
  } txn_t;

  typedef struct packed {
    logic ov;
    logic [63:0] rd, alu, bt;
    logic [4:0] wr;
    logic rw, m2r, pc, err;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] model [DEPTH];

  function automatic logic is_legal(input logic [63:0] a);
    return (a % 8 == 0) && (a / 8 < DEPTH);
  endfunction

  task automatic scramble_inputs();
    alu_result    = {$urandom, $urandom};
    branch_target = {$urandom, $urandom};
    read_data2    = {$urandom, $urandom};
    zero = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    branch = 1'($urandom); uncond_branch = 1'($urandom);
    reg_write = 1'($urandom); mem_to_reg = 1'($urandom);
    write_reg = 5'($urandom);
  endtask

  // Drives one transaction, returns what was seen when out_valid rose and the
  // number of negedges from the transfer edge to that point.
  task automatic run_txn(input txn_t t, output obs_t o, output int lat);
    int w;
    @(negedge clk);
    alu_result = t.alu; branch_target = t.bt; read_data2 = t.rd2;
    zero = t.zero; mem_read = t.mr; mem_write = t.mw; branch = t.br;
    uncond_branch = t.ub; reg_write = t.rw; mem_to_reg = t.m2r; write_reg = t.wr;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    o = '{out_valid, read_data, alu_result_out, branch_target_out, write_reg_out,
          reg_write_out, mem_to_reg_out, pc_src, mem_err};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    scramble_inputs();
    #12;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_cmp++;
    if ({out_valid, pc_src, mem_err, reg_write_out, mem_to_reg_out} !== 5'b0 ||
        write_reg_out !== 5'd0 || read_data !== 64'd0 || alu_result_out !== 64'd0 ||
        branch_target_out !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got ov=%b pc=%b err=%b rd=%h alu=%h bt=%h wr=%0d exp all 0",
               out_valid, pc_src, mem_err, read_data, alu_result_out, branch_target_out, write_reg_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_store();
    txn_t t; obs_t o; int lat;
    t = '0; t.alu = 64'd112; t.rd2 = 64'd101; t.mw = 1'b1;
    run_txn(t, o, lat);
    model[14] = 64'd101;
    n_cmp++;
    if (o.ov !== 1'b1 || lat != 1) begin n_bad++; $display("FAIL store_latency got ov=%b lat=%0d exp ov=1 lat=1", o.ov, lat); end
    n_cmp++;
    if (o.err !== 1'b0) begin n_bad++; $display("FAIL store_err got %b exp 0", o.err); end
  endtask

  task automatic test_load();
    txn_t t; obs_t o; int lat;
    t = '0; t.alu = 64'd112; t.mr = 1'b1; t.m2r = 1'b1; t.rw = 1'b1; t.wr = 5'd9;
    run_txn(t, o, lat);
    n_cmp++;
    if (o.ov !== 1'b1 || lat != 2) begin n_bad++; $display("FAIL load_latency got ov=%b lat=%0d exp ov=1 lat=2", o.ov, lat); end
    n_cmp++;
    if (o.rd !== 64'd101) begin n_bad++; $display("FAIL load_data got %0d exp 101", o.rd); end
    n_cmp++;
    if (o.wr !== 5'd9 || o.m2r !== 1'b1 || o.rw !== 1'b1) begin
      n_bad++; $display("FAIL load_ctrl got wr=%0d m2r=%b rw=%b exp wr=9 m2r=1 rw=1", o.wr, o.m2r, o.rw);
    end
  endtask

  task automatic test_branch();
    txn_t t; obs_t o; int lat;
    logic [2:0] zs [3]; // {branch, zero, uncond}
    logic exp_pc [3];
    zs[0] = 3'b110; exp_pc[0] = 1'b1;
    zs[1] = 3'b100; exp_pc[1] = 1'b0;
    zs[2] = 3'b001; exp_pc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = '0; t.bt = 64'h0C; t.br = zs[i][2]; t.zero = zs[i][1]; t.ub = zs[i][0];
      run_txn(t, o, lat);
      n_cmp++;
      if (o.pc !== exp_pc[i]) begin n_bad++; $display("FAIL branch_pc_src[%0d] got %b exp %b", i, o.pc, exp_pc[i]); end
      n_cmp++;
      if (o.bt !== 64'h0C) begin n_bad++; $display("FAIL branch_target[%0d] got %h exp 0c", i, o.bt); end
    end
  endtask

  task automatic test_illegal();
    txn_t t; obs_t o; int lat;
    logic [63:0] addrs [2];
    addrs[0] = 64'h104; addrs[1] = 64'h100;
    for (int i = 0; i < 2; i++) begin
      t = '0; t.alu = addrs[i]; t.mr = 1'b1;
      run_txn(t, o, lat);
      n_cmp++;
      if (o.err !== 1'b1 || o.rd !== 64'd0) begin
        n_bad++; $display("FAIL illegal_load[%h] got err=%b rd=%h exp err=1 rd=0", addrs[i], o.err, o.rd);
      end
    end
    // Unaligned store aimed at word 14 must not touch it.
    t = '0; t.alu = 64'd113; t.rd2 = 64'hDEAD; t.mw = 1'b1;
    run_txn(t, o, lat);
    n_cmp++;
    if (o.err !== 1'b1) begin n_bad++; $display("FAIL illegal_store_err got %b exp 1", o.err); end
    t = '0; t.alu = 64'd112; t.mr = 1'b1;
    run_txn(t, o, lat);
    n_cmp++;
    if (o.rd !== model[14]) begin n_bad++; $display("FAIL illegal_mem_unchanged got %0d exp %0d", o.rd, model[14]); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    scramble_inputs();
    alu_result = 64'd30; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
    uncond_branch = 1'b0; reg_write = 1'b1; write_reg = 5'd3;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    alu_result = 64'd999; write_reg = 5'd17;   // second request, must be ignored
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || alu_result_out !== 64'd30 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d] got ov=%b alu=%0d rdy=%b exp ov=1 alu=30 rdy=0",
                 c, out_valid, alu_result_out, in_ready);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL backpressure_release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
    end
    n_cmp++;
    if (write_reg_out !== 5'd3) begin n_bad++; $display("FAIL backpressure_no_capture got wr=%0d exp 3", write_reg_out); end
  endtask

  task automatic test_reset_mid_op();
    txn_t t; obs_t o; int lat;
    // Reset between transfer and the store edge: store is dropped.
    @(negedge clk);
    alu_result = 64'd112; read_data2 = 64'd555; mem_write = 1'b1; mem_read = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || mem_err !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_store got ov=%b err=%b rdy=%b exp 0 0 0", out_valid, mem_err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Reset while the load sits in READ.
    @(negedge clk);
    scramble_inputs();
    alu_result = 64'd112; mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
    reg_write = 1'b1; write_reg = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, pc_src, mem_err, reg_write_out, mem_to_reg_out} !== 5'b0 ||
        write_reg_out !== 5'd0 || read_data !== 64'd0 || alu_result_out !== 64'd0 ||
        branch_target_out !== 64'd0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_load got ov=%b rd=%h alu=%h wr=%0d rdy=%b exp all 0",
               out_valid, read_data, alu_result_out, write_reg_out, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_load_idle got rdy=%b ov=%b exp 1 0", in_ready, out_valid);
    end
    t = '0; t.alu = 64'd112; t.mr = 1'b1;
    run_txn(t, o, lat);
    n_cmp++;
    if (o.rd !== 64'd101) begin n_bad++; $display("FAIL reset_mem_retained got %0d exp 101", o.rd); end
  endtask

  task automatic test_random();
    txn_t t; obs_t o; int lat;
    logic lg, ld;
    int exp_lat;
    logic [63:0] exp_rd;
    for (int w = 0; w < DEPTH; w++) begin
      t = '0; t.alu = 64'(w * 8); t.rd2 = {$urandom, $urandom}; t.mw = 1'b1;
      run_txn(t, o, lat);
      model[w] = t.rd2;
    end
    for (int i = 0; i < 150; i++) begin
      t = '0;
      case ($urandom_range(0, 5))
        0: t.alu = {$urandom, $urandom};
        1: t.alu = 64'($urandom_range(DEPTH, DEPTH + 8) * 8);
        2: t.alu = 64'($urandom_range(0, DEPTH * 8 - 1));
        default: t.alu = 64'($urandom_range(0, DEPTH - 1) * 8);
      endcase
      t.bt = {$urandom, $urandom}; t.rd2 = {$urandom, $urandom};
      t.zero = 1'($urandom); t.mr = 1'($urandom); t.mw = 1'($urandom);
      t.br = 1'($urandom); t.ub = 1'($urandom); t.rw = 1'($urandom);
      t.m2r = 1'($urandom); t.wr = 5'($urandom);
      lg = is_legal(t.alu);
      ld = t.mr && !t.mw;
      exp_lat = ld ? 2 : 1;
      exp_rd = (ld && lg) ? model[t.alu / 8] : 64'd0;
      run_txn(t, o, lat);
      n_cmp++;
      if (o.ov !== 1'b1 || lat != exp_lat) begin
        n_bad++; $display("FAIL rnd_latency #%0d got ov=%b lat=%0d exp lat=%0d", i, o.ov, lat, exp_lat);
      end
      n_cmp++;
      if (o.rd !== exp_rd) begin n_bad++; $display("FAIL rnd_read_data #%0d got %h exp %h", i, o.rd, exp_rd); end
      n_cmp++;
      if (o.err !== ((t.mr || t.mw) && !lg)) begin
        n_bad++; $display("FAIL rnd_mem_err #%0d alu=%h got %b exp %b", i, t.alu, o.err, (t.mr || t.mw) && !lg);
      end
      n_cmp++;
      if (o.pc !== ((t.br && t.zero) || t.ub)) begin
        n_bad++; $display("FAIL rnd_pc_src #%0d got %b exp %b", i, o.pc, (t.br && t.zero) || t.ub);
      end
      n_cmp++;
      if (o.alu !== t.alu || o.bt !== t.bt || o.wr !== t.wr || o.rw !== t.rw || o.m2r !== t.m2r) begin
        n_bad++;
        $display("FAIL rnd_passthru #%0d got alu=%h bt=%h wr=%0d rw=%b m2r=%b exp alu=%h bt=%h wr=%0d rw=%b m2r=%b",
                 i, o.alu, o.bt, o.wr, o.rw, o.m2r, t.alu, t.bt, t.wr, t.rw, t.m2r);
      end
      if (t.mw && lg) model[t.alu / 8] = t.rd2;
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_branch();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
